// File: rtl/irda_fir_rx.sv
// irda_fir_rx: 4 Mb/s 4PPM (FIR) IrDA receive path.
//   Hunts for the preamble, locks the 4PPM symbol phase, matches the start flag,
//   decodes data symbols into bytes, detects the stop flag and checks the FCS.
// Optional feature macro: IRDA_FIR_RX_CRC_EN (CRC-32 engine and residue check).
//   Without it, crc_err flags only byte misalignment or a frame under 4 bytes.
// Ports:
//   clk            system clock
//   wb_rst_n       asynchronous active-low reset
//   fir_rx8_enable chip strobe, one chip per high cycle
//   fir_rx_i       sampled chip, valid with fir_rx8_enable
//   rx_restart     synchronous abort back to hunt
//   rx_data        received byte, held between rx_valid pulses
//   rx_valid       one-cycle pulse, rx_data valid
//   frame_start    one-cycle pulse on start flag match
//   frame_end      one-cycle pulse on stop flag match
//   crc_err        qualified by frame_end: bad residue or misaligned/short frame
//   symbol_err     one-cycle pulse on an illegal data symbol (frame aborted)
module irda_fir_rx #(
  parameter int unsigned PA_MATCHES  = 4,
  parameter int unsigned STA_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       fir_rx8_enable,
  input  logic       fir_rx_i,
  input  logic       rx_restart,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       crc_err,
  output logic       symbol_err
);

  localparam int unsigned PaW  = $clog2(PA_MATCHES + 1);
  localparam int unsigned TmoW = $clog2(STA_TIMEOUT + 1);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StPaLock = 2'd1;
  localparam logic [1:0] StData   = 2'd2;

  // Patterns in time order, oldest chip at the MSB.
  localparam logic [15:0] PaPat  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] StaPat = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] StoPat = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

  logic [1:0]      state_q, state_d;
  logic [31:0]     win_q, win_d, win_shift;
  logic [3:0]      cnt_q, cnt_d;          // chip counter; [1:0] is the symbol phase
  logic [PaW-1:0]  pa_cnt_q, pa_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [3:0]      sym_cnt_q, sym_cnt_d;  // saturates at 8 (lookahead filled)
  logic [1:0]      dib_q, dib_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      nbytes_q, nbytes_d;    // saturates at 4
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_end_q, frame_end_d;
  logic            crc_err_q, crc_err_d;
  logic            symbol_err_q, symbol_err_d;
  logic [1:0]      dibit;
  logic            sym_ok, take, crc_ok, boundary;

  assign win_shift = {win_q[30:0], fir_rx_i};
  assign boundary  = (cnt_q[1:0] == 2'd3);

  // Oldest symbol of the updated window is the one being decoded.
  always_comb begin
    dibit  = 2'd0;
    sym_ok = 1'b1;
    case (win_shift[31:28])
      4'b1000: dibit = 2'd0;
      4'b0100: dibit = 2'd1;
      4'b0010: dibit = 2'd2;
      4'b0001: dibit = 2'd3;
      default: sym_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    pa_cnt_d      = pa_cnt_q;
    tmo_d         = tmo_q;
    sym_cnt_d     = sym_cnt_q;
    dib_d         = dib_q;
    byte_d        = byte_q;
    nbytes_d      = nbytes_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    crc_err_d     = 1'b0;
    symbol_err_d  = 1'b0;
    take          = 1'b0;

    if (rx_restart) begin
      state_d   = StHunt;
      win_d     = '0;
      cnt_d     = '0;
      pa_cnt_d  = '0;
      tmo_d     = '0;
      sym_cnt_d = '0;
      dib_d     = '0;
      byte_d    = '0;
      nbytes_d  = '0;
      rx_data_d = '0;
    end else if (fir_rx8_enable) begin
      win_d = win_shift;
      cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        StHunt: begin
          if (pa_cnt_q == '0) begin
            // Free-running search: the first match fixes the symbol phase.
            if (win_shift[15:0] == PaPat) begin
              pa_cnt_d = PaW'(1);
              cnt_d    = '0;
            end
          end else if (cnt_q == 4'd15) begin
            pa_cnt_d = (win_shift[15:0] == PaPat) ? pa_cnt_q + 1'b1 : '0;
          end
          if (pa_cnt_d == PaW'(PA_MATCHES)) begin
            state_d  = StPaLock;
            pa_cnt_d = '0;
            tmo_d    = '0;
          end
        end
        StPaLock: begin
          tmo_d = tmo_q + 1'b1;
          if (boundary && win_shift == StaPat) begin
            state_d       = StData;
            frame_start_d = 1'b1;
            sym_cnt_d     = '0;
            dib_d         = '0;
            byte_d        = '0;
            nbytes_d      = '0;
          end else if (tmo_d == TmoW'(STA_TIMEOUT)) begin
            state_d = StHunt;
          end
        end
        StData: begin
          if (boundary) begin
            if (win_shift == StoPat) begin
              state_d     = StHunt;
              frame_end_d = 1'b1;
              crc_err_d   = ~(crc_ok && dib_q == 2'd0 && nbytes_q == 3'd4);
            end else begin
              if (sym_cnt_q != 4'd8) sym_cnt_d = sym_cnt_q + 4'd1;
              // The top symbol is data only once 8 symbols followed the flag.
              if (sym_cnt_d == 4'd8) begin
                if (sym_ok) begin
                  take = 1'b1;
                end else begin
                  symbol_err_d = 1'b1;
                  state_d      = StHunt;
                end
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (take) begin
      byte_d = {dibit, byte_q[7:2]};
      dib_d  = dib_q + 2'd1;
      if (dib_q == 2'd3) begin
        rx_valid_d = 1'b1;
        rx_data_d  = {dibit, byte_q[7:2]};
        if (nbytes_q != 3'd4) nbytes_d = nbytes_q + 3'd1;
      end
    end
  end

`ifdef IRDA_FIR_RX_CRC_EN
  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ CrcPoly) : (c >> 1);
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (rx_restart || frame_start_d) begin
      crc_d = '1;
    end else if (take) begin
      crc_d = crc_bit(crc_bit(crc_q, dibit[0]), dibit[1]);
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) crc_q <= '1;
    else           crc_q <= crc_d;
  end

  assign crc_ok = (crc_q == CrcResidue);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= StHunt;
      win_q         <= '0;
      cnt_q         <= '0;
      pa_cnt_q      <= '0;
      tmo_q         <= '0;
      sym_cnt_q     <= '0;
      dib_q         <= '0;
      byte_q        <= '0;
      nbytes_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      symbol_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      pa_cnt_q      <= pa_cnt_d;
      tmo_q         <= tmo_d;
      sym_cnt_q     <= sym_cnt_d;
      dib_q         <= dib_d;
      byte_q        <= byte_d;
      nbytes_q      <= nbytes_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      crc_err_q     <= crc_err_d;
      symbol_err_q  <= symbol_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign crc_err     = crc_err_q;
  assign symbol_err  = symbol_err_q;

endmodule

// File: tb/tb_irda_fir_rx.sv
// tb_irda_fir_rx: directed bench for irda_fir_rx; frames built from chip patterns,
// decoded bytes and pulses collected by a negedge monitor.
module tb_irda_fir_rx;

  localparam logic [15:0] Pa  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] Sta = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
  localparam logic [31:0] Sto = 32'b0000_1100_0000_1100_0000_0110_0000_0110;
`ifdef IRDA_FIR_RX_CRC_EN
  localparam logic ExpBadCrc = 1'b1;
`else
  localparam logic ExpBadCrc = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       fir_rx8_enable = 1'b0;
  logic       fir_rx_i = 1'b0;
  logic       rx_restart = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_start, frame_end, crc_err, symbol_err;

  irda_fir_rx dut (
    .clk            (clk),
    .wb_rst_n       (wb_rst_n),
    .fir_rx8_enable (fir_rx8_enable),
    .fir_rx_i       (fir_rx_i),
    .rx_restart     (rx_restart),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .frame_start    (frame_start),
    .frame_end      (frame_end),
    .crc_err        (crc_err),
    .symbol_err     (symbol_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];
  int         n_start = 0, n_end = 0, n_symerr = 0, n_stray = 0;
  logic       last_crc_err = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (frame_start) n_start++;
    if (frame_end) begin
      n_end++;
      last_crc_err = crc_err;
    end else if (crc_err) begin
      n_stray++;
    end
    if (symbol_err) n_symerr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, rx_data, rx_valid, frame_start, frame_end, crc_err, symbol_err};
  endfunction

  // Reference CRC-32 (reflected, init all ones) over tx_q.
  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    c = '1;
    foreach (tx_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ tx_q[k][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                   c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic send_chip(input logic b);
    @(negedge clk);
    fir_rx8_enable = 1'b1;
    fir_rx_i       = b;
    @(negedge clk);
    fir_rx8_enable = 1'b0;
    fir_rx_i       = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_chip(v[i]);
  endtask

  task automatic send_sym(input logic [1:0] d);
    logic [3:0] c;
    c = 4'b1000 >> d;
    send_bits({28'd0, c}, 4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) send_sym(b[2*k +: 2]);
  endtask

  task automatic send_head(input int npa);
    for (int i = 0; i < npa; i++) send_bits({16'd0, Pa}, 16);
    send_bits(Sta, 32);
  endtask

  task automatic send_frame(input int npa);
    send_head(npa);
    foreach (tx_q[k]) send_byte(tx_q[k]);
    send_bits(Sto, 32);
    send_bits(32'd0, 32);
  endtask

  task automatic build_good();
    logic [31:0] fcs;
    tx_q.delete();
    tx_q.push_back(8'h01);
    tx_q.push_back(8'hA5);
    fcs = ~crc_model();
    for (int k = 0; k < 4; k++) tx_q.push_back(fcs[8*k +: 8]);
  endtask

  task automatic expect_bytes(input string tag, input int base);
    check_eq({tag, "_count"}, rx_log.size() - base, tx_q.size());
    foreach (tx_q[k]) begin
      logic [7:0] got;
      got = (base + k < rx_log.size()) ? rx_log[base + k] : 8'hxx;
      check_eq($sformatf("%s_byte%0d", tag, k), {24'd0, got}, {24'd0, tx_q[k]});
    end
  endtask

  task automatic good_frame(input string tag);
    int s0, e0, b0;
    s0 = n_start; e0 = n_end; b0 = rx_log.size();
    build_good();
    send_frame(4);
    check_eq({tag, "_start"}, n_start - s0, 1);
    check_eq({tag, "_end"}, n_end - e0, 1);
    check_eq({tag, "_crc_err"}, {31'd0, last_crc_err}, 0);
    expect_bytes(tag, b0);
  endtask

  initial begin
    int s0, e0, b0, x0;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", outs(), 0);
    wb_rst_n = 1'b1;
    send_bits(32'd0, 16);

    good_frame("frame1");

    // Legal but wrong symbol in the first byte: 01 becomes 02.
    s0 = n_start; e0 = n_end; b0 = rx_log.size();
    build_good();
    tx_q[0] = 8'h02;
    send_frame(4);
    check_eq("moved_end", n_end - e0, 1);
    check_eq("moved_crc_err", {31'd0, last_crc_err}, {31'd0, ExpBadCrc});
    expect_bytes("moved", b0);

    // Illegal symbol after one byte.
    e0 = n_end; b0 = rx_log.size(); x0 = n_symerr;
    send_head(4);
    send_byte(8'h01);
    send_bits(32'hC, 4);
    send_bits(32'd0, 32);
    send_bits(32'd0, 32);
    tx_q.delete();
    tx_q.push_back(8'h01);
    check_eq("symerr_pulse", n_symerr - x0, 1);
    check_eq("symerr_no_end", n_end - e0, 0);
    expect_bytes("symerr", b0);
    good_frame("after_symerr");

    // Three preamble periods are not enough.
    s0 = n_start; b0 = rx_log.size();
    build_good();
    send_frame(3);
    check_eq("pa3_no_start", n_start - s0, 0);
    check_eq("pa3_no_bytes", rx_log.size() - b0, 0);

    // Lock, then 64 chips of noise: the start flag must no longer be accepted.
    s0 = n_start; b0 = rx_log.size();
    for (int i = 0; i < 4; i++) send_bits({16'd0, Pa}, 16);
    send_bits(32'h5555_5555, 32);
    send_bits(32'h5555_5555, 32);
    send_bits(Sta, 32);
    send_byte(8'h01);
    send_bits(Sto, 32);
    send_bits(32'd0, 32);
    check_eq("timeout_no_start", n_start - s0, 0);
    check_eq("timeout_no_bytes", rx_log.size() - b0, 0);
    good_frame("after_timeout");

    // Stop flag after 5 data symbols.
    e0 = n_end; b0 = rx_log.size();
    send_head(4);
    send_sym(2'd0); send_sym(2'd1); send_sym(2'd2); send_sym(2'd3); send_sym(2'd0);
    send_bits(Sto, 32);
    send_bits(32'd0, 32);
    tx_q.delete();
    tx_q.push_back(8'hE4);
    check_eq("odd_end", n_end - e0, 1);
    check_eq("odd_crc_err", {31'd0, last_crc_err}, 1);
    expect_bytes("odd", b0);

    // Synchronous restart mid-frame; the strobe in that cycle is dropped.
    e0 = n_end; b0 = rx_log.size();
    send_head(4);
    send_byte(8'h01); send_byte(8'hA5); send_byte(8'h3C);
    check_eq("restart_pre_bytes", rx_log.size() - b0, 1);
    @(negedge clk);
    rx_restart     = 1'b1;
    fir_rx8_enable = 1'b1;
    fir_rx_i       = 1'b1;
    @(negedge clk);
    rx_restart     = 1'b0;
    fir_rx8_enable = 1'b0;
    fir_rx_i       = 1'b0;
    check_eq("restart_outputs", outs(), 0);
    send_byte(8'h5A);
    send_bits(Sto, 32);
    send_bits(32'd0, 32);
    check_eq("restart_no_valid", rx_log.size() - b0, 1);
    check_eq("restart_no_end", n_end - e0, 0);

    // Asynchronous reset mid-frame.
    e0 = n_end; b0 = rx_log.size();
    send_head(4);
    send_byte(8'h01); send_byte(8'hA5); send_byte(8'h3C);
    @(negedge clk);
    wb_rst_n = 1'b0;
    #1;
    check_eq("areset_outputs", outs(), 0);
    @(negedge clk);
    wb_rst_n = 1'b1;
    send_byte(8'h5A);
    send_bits(Sto, 32);
    send_bits(32'd0, 32);
    check_eq("areset_no_valid", rx_log.size() - b0, 1);
    check_eq("areset_no_end", n_end - e0, 0);
    good_frame("final");

    check_eq("crc_err_stray", n_stray, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
